// File: rtl/calc1_req_driver.sv
// calc1_req_driver: drives one calc1 request port (cmd+op1 cycle, then op2 cycle), waits for the
// response or a timeout, and holds the result until taken. Optional CALC1_DRV_CHECK_EN adds rsp_mismatch.
module calc1_req_driver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:3]  req_cmd,
  input  logic [0:31] req_op1,
  input  logic [0:31] req_op2,
  output logic [0:3]  cmd_out,
  output logic [0:31] data_out,
  input  logic [0:1]  resp_in,
  input  logic [0:31] resp_data_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:1]  rsp_code,
  output logic [0:31] rsp_data,
`ifdef CALC1_DRV_CHECK_EN
  output logic        rsp_mismatch,
`endif
  output logic        rsp_timeout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP1  = 3'd1,
    S_OP2  = 3'd2,
    S_WAIT = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t            state_q;
  logic              req_ready_q;
  logic [0:3]        cmd_out_q;
  logic [0:31]       data_out_q;
  logic [0:31]       op2_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              rsp_valid_q;
  logic [0:1]        rsp_code_q;
  logic [0:31]       rsp_data_q;
  logic              rsp_timeout_q;

  assign cnt_d = cnt_q + CNT_W'(1);

`ifdef CALC1_DRV_CHECK_EN
  logic [0:3]  cmd_q;
  logic [0:31] op1_q;
  logic        mismatch_q;

  // Reference calc1 result for the latched operation; 1 when the returned response disagrees.
  function automatic logic calc_mismatch(input logic [0:3] cmd, input logic [0:31] a,
                                         input logic [0:31] b, input logic [0:1] code,
                                         input logic [0:31] data);
    logic [32:0] sum;
    logic [0:31] exp_data;
    logic [0:1]  exp_code;
    sum      = {1'b0, a} + {1'b0, b};
    exp_data = 32'd0;
    exp_code = 2'd3;
    case (cmd)
      4'd1: begin
        exp_data = sum[31:0];
        exp_code = sum[32] ? 2'd2 : 2'd1;
      end
      4'd2: begin
        exp_data = a - b;
        exp_code = (b > a) ? 2'd2 : 2'd1;
      end
      4'd5: begin
        exp_data = a << b[27:31];
        exp_code = 2'd1;
      end
      4'd6: begin
        exp_data = a >> b[27:31];
        exp_code = 2'd1;
      end
      default: begin
        exp_data = 32'd0;
        exp_code = 2'd3;
      end
    endcase
    return (code != exp_code) || ((exp_code == 2'd1) && (data != exp_data));
  endfunction

  // Latch the operands the checker needs and register its verdict at capture time.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      cmd_q      <= 4'd0;
      op1_q      <= 32'd0;
      mismatch_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && req_valid && req_ready_q) begin
        cmd_q <= req_cmd;
        op1_q <= req_op1;
      end
      if (state_q == S_WAIT) begin
        if (resp_in != 2'd0) begin
          mismatch_q <= calc_mismatch(cmd_q, op1_q, op2_q, resp_in, resp_data_in);
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          mismatch_q <= 1'b1;
        end
      end
    end
  end

  assign rsp_mismatch = mismatch_q;
`endif

  // Main sequencer: request serialisation, response wait/timeout and result hold.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      cmd_out_q     <= 4'd0;
      data_out_q    <= 32'd0;
      op2_q         <= 32'd0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= 2'd0;
      rsp_data_q    <= 32'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            op2_q       <= req_op2;
            cmd_out_q   <= req_cmd;
            data_out_q  <= req_op1;
            req_ready_q <= 1'b0;
            state_q     <= S_OP1;
          end else begin
            cmd_out_q   <= 4'd0;
            data_out_q  <= 32'd0;
            req_ready_q <= 1'b1;
          end
        end
        S_OP1: begin
          cmd_out_q  <= 4'd0;
          data_out_q <= op2_q;
          state_q    <= S_OP2;
        end
        S_OP2: begin
          cmd_out_q  <= 4'd0;
          data_out_q <= 32'd0;
          cnt_q      <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // A response wins over a timeout landing in the same cycle.
          if (resp_in != 2'd0) begin
            rsp_code_q    <= resp_in;
            rsp_data_q    <= resp_data_in;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_HOLD;
          end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            rsp_code_q    <= 2'd0;
            rsp_data_q    <= 32'd0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_HOLD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b0;
          cmd_out_q   <= 4'd0;
          data_out_q  <= 32'd0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign cmd_out     = cmd_out_q;
  assign data_out    = data_out_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_calc1_req_driver.sv
// Randomized self-checking bench for calc1_req_driver against a transaction-level calc1 model.
module tb_calc1_req_driver;

  localparam int T = 64;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [0:3]  req_cmd;
  logic [0:31] req_op1;
  logic [0:31] req_op2;
  logic [0:3]  cmd_out;
  logic [0:31] data_out;
  logic [0:1]  resp_in;
  logic [0:31] resp_data_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_code;
  logic [0:31] rsp_data;
  logic        rsp_timeout;
`ifdef CALC1_DRV_CHECK_EN
  logic        rsp_mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  calc1_req_driver #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .cmd_out      (cmd_out),
    .data_out     (data_out),
    .resp_in      (resp_in),
    .resp_data_in (resp_data_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_code     (rsp_code),
    .rsp_data     (rsp_data),
`ifdef CALC1_DRV_CHECK_EN
    .rsp_mismatch (rsp_mismatch),
`endif
    .rsp_timeout  (rsp_timeout)
  );

  always #5 c_clk = ~c_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // What a correct calc1 returns for an operation.
  function automatic void calc_model(input logic [0:3] cmd, input logic [0:31] a, input logic [0:31] b,
                                     output logic [0:1] code, output logic [0:31] data);
    logic [63:0] wide;
    int          sh;
    sh   = int'(b & 32'd31);
    code = 2'd3;
    data = 32'd0;
    case (cmd)
      4'd1: begin
        wide = {32'd0, a} + {32'd0, b};
        data = wide[31:0];
        code = (wide > 64'h0000_0000_FFFF_FFFF) ? 2'd2 : 2'd1;
      end
      4'd2: begin
        data = a - b;
        code = (b > a) ? 2'd2 : 2'd1;
      end
      4'd5: begin data = a << sh; code = 2'd1; end
      4'd6: begin data = a >> sh; code = 2'd1; end
      default: begin code = 2'd3; data = 32'd0; end
    endcase
  endfunction

  // One full operation; starts and ends #1 after a rising edge with the driver idle.
  task automatic run_op(input logic [0:3] cmd, input logic [0:31] a, input logic [0:31] b,
                        input int delay, input logic [0:1] rcode, input logic [0:31] rdata,
                        input int hold, input bit spurious);
    logic       timed_out;
    logic [0:1] ecode;
    logic [0:31] edata;
    logic [0:1] mcode;
    logic [0:31] mdata;
    bit         done;
    timed_out = (delay >= T);
    ecode = timed_out ? 2'd0 : rcode;
    edata = timed_out ? 32'd0 : rdata;
    calc_model(cmd, a, b, mcode, mdata);

    check_val("idle_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_cmd = cmd; req_op1 = a; req_op2 = b;
    resp_in = spurious ? 2'd1 : 2'd0; resp_data_in = $urandom;
    @(posedge c_clk); #1;
    req_valid = 1'b0; req_cmd = 4'($urandom); req_op1 = $urandom; req_op2 = $urandom;
    check_val("op1_cmd", cmd_out, cmd);
    check_val("op1_data", data_out, a);
    check_val("op1_req_ready", req_ready, 1'b0);
    resp_in = spurious ? 2'd1 : 2'd0; resp_data_in = $urandom;
    @(posedge c_clk); #1;
    check_val("op2_cmd", cmd_out, 4'd0);
    check_val("op2_data", data_out, b);
    resp_in = spurious ? 2'd1 : 2'd0; resp_data_in = $urandom;
    @(posedge c_clk); #1;
    check_val("wait_cmd", cmd_out, 4'd0);
    check_val("wait_data", data_out, 32'd0);
    check_val("wait_rsp_valid", rsp_valid, 1'b0);

    done = 1'b0;
    for (int i = 0; i < T && !done; i++) begin
      if (i == delay) begin resp_in = rcode; resp_data_in = rdata; end
      else begin resp_in = 2'd0; resp_data_in = $urandom; end
      @(posedge c_clk); #1;
      if (i == delay || i == T - 1) done = 1'b1;
      else check_val("wait_no_rsp", rsp_valid, 1'b0);
    end
    resp_in = 2'd0;

    for (int h = 0; h <= hold; h++) begin
      check_val("hold_valid", rsp_valid, 1'b1);
      check_val("hold_code", rsp_code, ecode);
      check_val("hold_data", rsp_data, edata);
      check_val("hold_timeout", rsp_timeout, timed_out);
      check_val("hold_req_ready", req_ready, 1'b0);
`ifdef CALC1_DRV_CHECK_EN
      check_val("hold_mismatch", rsp_mismatch,
                timed_out | (ecode != mcode) | ((mcode == 2'd1) & (edata != mdata)));
`endif
      rsp_ready = (h == hold);
      resp_in = 2'($urandom); resp_data_in = $urandom;
      @(posedge c_clk); #1;
    end
    rsp_ready = 1'b0; resp_in = 2'd0;
    check_val("post_rsp_valid", rsp_valid, 1'b0);
    check_val("post_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    logic [0:3]  c;
    logic [0:31] a, b, d;
    logic [0:1]  rc;
    int          dly;
    reset = 1'b1; req_valid = 1'b0; req_cmd = 4'd0; req_op1 = 32'd0; req_op2 = 32'd0;
    resp_in = 2'd0; resp_data_in = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge c_clk);
    #1;
    check_val("rst_req_ready", req_ready, 1'b0);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_cmd_out", cmd_out, 4'd0);
    check_val("rst_data_out", data_out, 32'd0);
    check_val("rst_rsp_code", rsp_code, 2'd0);
    check_val("rst_rsp_data", rsp_data, 32'd0);
    check_val("rst_timeout", rsp_timeout, 1'b0);
    reset = 1'b0;
    @(posedge c_clk); #1;
    check_val("rel_req_ready", req_ready, 1'b1);

    run_op(4'd1, 32'd5, 32'd7, 0, 2'd1, 32'd12, 1, 1'b0);
    run_op(4'd2, 32'd3, 32'd4, 3, 2'd2, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(4'd1, 32'd9, 32'd9, T + 5, 2'd1, 32'd18, 10, 1'b0);
    run_op(4'd5, 32'd1, 32'd7, 2, 2'd1, 32'h80, 2, 1'b1);
    run_op(4'd1, 32'hFFFF_FFFF, 32'd1, 1, 2'd1, 32'd0, 0, 1'b0);
    run_op(4'd0, 32'd11, 32'd22, 0, 2'd3, 32'd0, 0, 1'b0);
    run_op(4'd6, 32'h8000_0000, 32'd31, T - 1, 2'd1, 32'd1, 0, 1'b0);

    // Abort in the middle of WAIT with an asynchronous reset.
    req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'd1; req_op2 = 32'd2;
    @(posedge c_clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge c_clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("abort_rsp_valid", rsp_valid, 1'b0);
    check_val("abort_cmd_out", cmd_out, 4'd0);
    check_val("abort_req_ready", req_ready, 1'b0);
    @(posedge c_clk); #1;
    reset = 1'b0;
    @(posedge c_clk); #1;
    check_val("abort_rel_req_ready", req_ready, 1'b1);
    check_val("abort_rel_rsp_valid", rsp_valid, 1'b0);
    check_val("abort_rel_cmd_out", cmd_out, 4'd0);
    run_op(4'd2, 32'd100, 32'd1, 1, 2'd1, 32'd99, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      c = 4'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      calc_model(c, a, b, rc, d);
      if ($urandom_range(0, 3) == 0) begin
        rc = 2'($urandom_range(1, 3));
        d  = $urandom;
      end
      dly = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, 12);
      run_op(c, a, b, dly, rc, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
